id_issue_ctrl: RTL and testbench

ID_ISSUE_CTRL -- requirements
Module: id_issue_ctrl

---
 rtl/ch0re_types.sv | 13 +
 rtl/reg_scoreboard.sv | 43 ++++
 rtl/id_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_id_issue_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ch0re_types.sv
// Shared types for the ID/issue stage: issue FSM encoding and the canonical nop.
package ch0re_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    TRAP = 2'd2
  } id_issue_state_t;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int unsigned NREGS = 32;

endpackage

// File: rtl/reg_scoreboard.sv
// Register busy scoreboard: one bit per architectural register, x0 never busy.
module reg_scoreboard
  import ch0re_types::*;
(
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 set_en,
  input  logic [4:0]           waddr,
  input  logic                 clr_en,
  input  logic [4:0]           clr_addr,
  input  logic [4:0]           raddr1,
  input  logic [4:0]           raddr2,
  output logic                 rbusy1,
  output logic                 rbusy2,
  output logic [NREGS-1:0]     busy
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  assign busy_next[0] = 1'b0;

  // Set is ORed in after the clear so a same-cycle issue keeps the bit busy.
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_bit
      assign busy_next[gi] = (set_en && (waddr == 5'(gi))) ||
                             (busy_reg[gi] && !(clr_en && (clr_addr == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign rbusy1 = busy_reg[raddr1];
  assign rbusy2 = busy_reg[raddr2];
  assign busy   = busy_reg;

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode/issue control: holds one fetched instruction, checks register hazards
// against the scoreboard, issues to EX, and parks illegal instructions in TRAP.
module id_issue_ctrl
  import ch0re_types::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_valid,
  input  logic [31:0] i_fetch_instr,
  input  logic [63:0] i_fetch_pc,
  output logic        o_fetch_ready,
  output logic [31:0] o_dec_instr,
  input  logic        i_dec_illegal,
  input  logic        i_dec_rs1_en,
  input  logic        i_dec_rs2_en,
  input  logic        i_dec_rd_en,
  input  logic [4:0]  i_dec_raddr1,
  input  logic [4:0]  i_dec_raddr2,
  input  logic [4:0]  i_dec_waddr,
  output logic        o_issue_valid,
  input  logic        i_issue_ready,
  output logic [63:0] o_issue_pc,
  output logic [31:0] o_issue_instr,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_waddr,
  input  logic        i_flush,
  output logic        o_trap,
  output logic [63:0] o_trap_pc,
  output logic [15:0] o_stall_cnt
);

  id_issue_state_t  state_reg, state_next;
  logic [31:0]      instr_reg, instr_next;
  logic [63:0]      pc_reg, pc_next;
  logic [15:0]      stall_cnt_reg, stall_cnt_next;

  logic             hazard;
  logic             issue_fire;
  logic             fetch_fire;
  logic             sb_set;
  logic             rbusy1;
  logic             rbusy2;
  logic [NREGS-1:0] busy;

  reg_scoreboard u_sb (
    .clk      (i_clk),
    .srst     (i_rst),
    .set_en   (sb_set),
    .waddr    (i_dec_waddr),
    .clr_en   (i_wb_valid),
    .clr_addr (i_wb_waddr),
    .raddr1   (i_dec_raddr1),
    .raddr2   (i_dec_raddr2),
    .rbusy1   (rbusy1),
    .rbusy2   (rbusy2),
    .busy     (busy)
  );

  // Hazards look only at the registered busy bits: a writeback unblocks next cycle.
  assign hazard = (i_dec_rs1_en && (i_dec_raddr1 != 5'd0) && rbusy1) ||
                  (i_dec_rs2_en && (i_dec_raddr2 != 5'd0) && rbusy2) ||
                  (i_dec_rd_en  && (i_dec_waddr  != 5'd0) && busy[i_dec_waddr]);

  assign issue_fire = o_issue_valid && i_issue_ready;
  assign fetch_fire = i_fetch_valid && o_fetch_ready;
  assign sb_set     = issue_fire && i_dec_rd_en && (i_dec_waddr != 5'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      instr_reg     <= NOP;
      pc_reg        <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      instr_reg     <= instr_next;
      pc_reg        <= pc_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (i_flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (fetch_fire) state_next = HOLD;
        HOLD: begin
          if (i_dec_illegal) begin
            state_next = TRAP;
          end else if (issue_fire) begin
            state_next = fetch_fire ? HOLD : IDLE;
          end
        end
        TRAP:    state_next = TRAP;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_issue_valid = 1'b0;
    o_fetch_ready = 1'b0;
    o_trap        = 1'b0;
    o_trap_pc     = '0;
    case (state_reg)
      IDLE: o_fetch_ready = !i_flush && !i_rst;
      HOLD: begin
        o_issue_valid = !hazard && !i_dec_illegal && !i_flush && !i_rst;
        o_fetch_ready = o_issue_valid && i_issue_ready;
      end
      TRAP: begin
        o_trap    = 1'b1;
        o_trap_pc = pc_reg;
      end
      default: o_fetch_ready = 1'b0;
    endcase
  end

  always_comb begin
    instr_next     = instr_reg;
    pc_next        = pc_reg;
    stall_cnt_next = stall_cnt_reg;
    if (fetch_fire) begin
      instr_next = i_fetch_instr;
      pc_next    = i_fetch_pc;
    end
    if ((state_reg == HOLD) && hazard && !i_flush && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_next = stall_cnt_reg + 16'd1;
    end
  end

  assign o_dec_instr   = instr_reg;
  assign o_issue_pc    = pc_reg;
  assign o_issue_instr = instr_reg;
  assign o_stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: acts as the external decoder and compares the DUT
// against a cycle-level model of the hold/issue/trap rules and busy registers.
module tb_id_issue_ctrl;

  localparam logic [31:0] NOP_I = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, fetch_valid, issue_ready, wb_valid, flush;
  logic [31:0] fetch_instr;
  logic [63:0] fetch_pc;
  logic [4:0]  wb_waddr;
  logic        fetch_ready, issue_valid, trap;
  logic [31:0] dec_instr, issue_instr;
  logic [63:0] issue_pc, trap_pc;
  logic [15:0] stall_cnt;

  typedef struct packed {
    logic       ill;
    logic       r1e;
    logic       r2e;
    logic       rde;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [4:0] wa;
  } dec_t;

  // Minimal RV decoder: OP-IMM and OP are legal, everything else is illegal.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    logic is_i, is_r;
    is_i  = (ins[6:0] == 7'h13);
    is_r  = (ins[6:0] == 7'h33);
    d.ill = !(is_i || is_r);
    d.r1e = is_i || is_r;
    d.r2e = is_r;
    d.rde = is_i || is_r;
    d.r1  = ins[19:15];
    d.r2  = ins[24:20];
    d.wa  = ins[11:7];
    return d;
  endfunction

  dec_t dd;
  assign dd = decode(dec_instr);

  always #5 clk = ~clk;

  id_issue_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_fetch_valid (fetch_valid),
    .i_fetch_instr (fetch_instr),
    .i_fetch_pc    (fetch_pc),
    .o_fetch_ready (fetch_ready),
    .o_dec_instr   (dec_instr),
    .i_dec_illegal (dd.ill),
    .i_dec_rs1_en  (dd.r1e),
    .i_dec_rs2_en  (dd.r2e),
    .i_dec_rd_en   (dd.rde),
    .i_dec_raddr1  (dd.r1),
    .i_dec_raddr2  (dd.r2),
    .i_dec_waddr   (dd.wa),
    .o_issue_valid (issue_valid),
    .i_issue_ready (issue_ready),
    .o_issue_pc    (issue_pc),
    .o_issue_instr (issue_instr),
    .i_wb_valid    (wb_valid),
    .i_wb_waddr    (wb_waddr),
    .i_flush       (flush),
    .o_trap        (trap),
    .o_trap_pc     (trap_pc),
    .o_stall_cnt   (stall_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: is an instruction held, is it a parked illegal one, and its contents.
  logic        m_held, m_trap;
  logic [31:0] m_instr;
  logic [63:0] m_pc;
  logic [31:0] m_busy;
  logic [15:0] m_stall;

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction

  function automatic logic m_hazard();
    dec_t d;
    d = decode(m_instr);
    return (d.r1e && d.r1 != 0 && m_busy[d.r1]) ||
           (d.r2e && d.r2 != 0 && m_busy[d.r2]) ||
           (d.rde && d.wa != 0 && m_busy[d.wa]);
  endfunction

  function automatic logic exp_iv();
    dec_t d;
    d = decode(m_instr);
    return m_held && !m_trap && !m_hazard() && !d.ill && !flush && !rst;
  endfunction

  function automatic logic exp_fr();
    return !flush && !rst && (!m_held || (exp_iv() && issue_ready));
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
    issue_ready = 1'b0; wb_valid = 1'b0; wb_waddr = '0; flush = 1'b0;
  endtask

  // Advance one clock edge and move the model forward with the inputs of that cycle.
  task automatic tick();
    dec_t d;
    logic hz, ifire, ffire;
    logic [31:0] nb;
    d     = decode(m_instr);
    hz    = m_hazard();
    ifire = exp_iv() && issue_ready;
    ffire = fetch_valid && exp_fr();
    @(posedge clk);
    #1;
    if (rst) begin
      m_held = 0; m_trap = 0; m_instr = NOP_I; m_pc = '0; m_busy = '0; m_stall = '0;
    end else begin
      nb = m_busy;
      if (wb_valid && wb_waddr != 0) nb[wb_waddr] = 1'b0;
      if (ifire && d.rde && d.wa != 0) nb[d.wa] = 1'b1;
      m_busy = nb;
      if (m_held && !m_trap && hz && !flush && m_stall != 16'hFFFF) m_stall = m_stall + 1;
      if (flush) begin
        m_held = 0; m_trap = 0;
      end else if (m_held && !m_trap) begin
        if (d.ill) m_trap = 1;
        else if (ifire) begin
          if (ffire) begin m_instr = fetch_instr; m_pc = fetch_pc; end
          else m_held = 0;
        end
      end else if (!m_held && ffire) begin
        m_held = 1; m_instr = fetch_instr; m_pc = fetch_pc;
      end
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL rst_cycle_issue got %0b want 0", issue_valid); else n_pass++;
    tick();
    rst = 1'b0;
    #2;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL reset_issue_valid got %0b want 0", issue_valid); else n_pass++;
    n_checks++; if (trap !== 1'b0) $display("FAIL reset_trap got %0b want 0", trap); else n_pass++;
    n_checks++; if (trap_pc !== 64'h0) $display("FAIL reset_trap_pc got %h want 0", trap_pc); else n_pass++;
    n_checks++; if (fetch_ready !== 1'b1) $display("FAIL reset_fetch_ready got %0b want 1", fetch_ready); else n_pass++;
    n_checks++; if (stall_cnt !== 16'h0) $display("FAIL reset_stall got %0d want 0", stall_cnt); else n_pass++;
    n_checks++; if (dec_instr !== NOP_I) $display("FAIL reset_dec_instr got %h want %h", dec_instr, NOP_I); else n_pass++;
    $display("reset done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue_ready = 1'b1;
    fetch_valid = 1'b1; fetch_instr = addi(5, 1, 1); fetch_pc = 64'h1000;
    #2;
    n_checks++; if (fetch_ready !== 1'b1) $display("FAIL b2b_first_ready got %0b want 1", fetch_ready); else n_pass++;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL b2b_latency got %0b want 0", issue_valid); else n_pass++;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        fetch_valid = 1'b1; fetch_instr = addi(6 + k, 1, 1); fetch_pc = 64'h1004 + 64'(4 * k);
      end else begin
        fetch_valid = 1'b0;
      end
      #2;
      n_checks++; if (issue_valid !== 1'b1) $display("FAIL b2b_valid%0d got %0b want 1", k, issue_valid); else n_pass++;
      n_checks++; if (issue_instr !== addi(5 + k, 1, 1)) $display("FAIL b2b_instr%0d got %h want %h", k, issue_instr, addi(5 + k, 1, 1)); else n_pass++;
      n_checks++; if (issue_pc !== 64'h1000 + 64'(4 * k)) $display("FAIL b2b_pc%0d got %h want %h", k, issue_pc, 64'h1000 + 64'(4 * k)); else n_pass++;
      $display("issue pc=%h instr=%h", issue_pc, issue_instr);
      tick();
    end
    #2;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL b2b_drained got %0b want 0", issue_valid); else n_pass++;
    n_checks++; if (stall_cnt !== 16'h0) $display("FAIL b2b_stall got %0d want 0", stall_cnt); else n_pass++;
  endtask

  task automatic test_raw();
    do_reset();
    issue_ready = 1'b1;
    fetch_valid = 1'b1; fetch_instr = add(5, 1, 2); fetch_pc = 64'h100;
    #2; tick();
    fetch_instr = add(6, 5, 5); fetch_pc = 64'h104;
    #2;
    n_checks++; if (issue_valid !== 1'b1) $display("FAIL raw_producer got %0b want 1", issue_valid); else n_pass++;
    tick();
    fetch_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #2;
      n_checks++; if (issue_valid !== 1'b0) $display("FAIL raw_stall%0d got %0b want 0", s, issue_valid); else n_pass++;
      tick();
    end
    wb_valid = 1'b1; wb_waddr = 5'd5;
    #2;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL raw_no_bypass got %0b want 0", issue_valid); else n_pass++;
    tick();
    wb_valid = 1'b0;
    #2;
    n_checks++; if (issue_valid !== 1'b1) $display("FAIL raw_release got %0b want 1", issue_valid); else n_pass++;
    n_checks++; if (issue_pc !== 64'h104) $display("FAIL raw_pc got %h want 104", issue_pc); else n_pass++;
    n_checks++; if (stall_cnt !== 16'd4) $display("FAIL raw_stall_cnt got %0d want 4", stall_cnt); else n_pass++;
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    issue_ready = 1'b1;
    fetch_valid = 1'b1; fetch_instr = addi(0, 0, 1); fetch_pc = 64'h200;
    #2; tick();
    fetch_instr = addi(1, 0, 5); fetch_pc = 64'h204;
    #2;
    n_checks++; if (issue_valid !== 1'b1) $display("FAIL x0_first got %0b want 1", issue_valid); else n_pass++;
    tick();
    fetch_valid = 1'b0;
    #2;
    n_checks++; if (issue_valid !== 1'b1) $display("FAIL x0_no_stall got %0b want 1", issue_valid); else n_pass++;
    n_checks++; if (dut.busy !== 32'h0) $display("FAIL x0_busy got %h want 0", dut.busy); else n_pass++;
    n_checks++; if (stall_cnt !== 16'h0) $display("FAIL x0_stall got %0d want 0", stall_cnt); else n_pass++;
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    issue_ready = 1'b1;
    fetch_valid = 1'b1; fetch_instr = 32'h0; fetch_pc = 64'h80;
    #2; tick();
    fetch_instr = addi(1, 1, 1); fetch_pc = 64'h84;
    #2;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL ill_hold_issue got %0b want 0", issue_valid); else n_pass++;
    n_checks++; if (fetch_ready !== 1'b0) $display("FAIL ill_hold_ready got %0b want 0", fetch_ready); else n_pass++;
    tick();
    for (int s = 0; s < 2; s++) begin
      #2;
      n_checks++; if (trap !== 1'b1) $display("FAIL ill_trap%0d got %0b want 1", s, trap); else n_pass++;
      n_checks++; if (trap_pc !== 64'h80) $display("FAIL ill_trap_pc%0d got %h want 80", s, trap_pc); else n_pass++;
      n_checks++; if (issue_valid !== 1'b0 || fetch_ready !== 1'b0) $display("FAIL ill_quiet%0d got %0b%0b want 00", s, issue_valid, fetch_ready); else n_pass++;
      tick();
    end
    fetch_valid = 1'b0; flush = 1'b1;
    #2;
    n_checks++; if (fetch_ready !== 1'b0) $display("FAIL ill_flush_ready got %0b want 0", fetch_ready); else n_pass++;
    tick();
    flush = 1'b0;
    #2;
    n_checks++; if (fetch_ready !== 1'b1) $display("FAIL ill_exit_ready got %0b want 1", fetch_ready); else n_pass++;
    n_checks++; if (trap !== 1'b0) $display("FAIL ill_exit_trap got %0b want 0", trap); else n_pass++;
  endtask

  task automatic stall_on_x5();
    issue_ready = 1'b1;
    fetch_valid = 1'b1; fetch_instr = add(5, 1, 2); fetch_pc = 64'h300;
    #2; tick();
    fetch_instr = add(6, 5, 5); fetch_pc = 64'h304;
    #2; tick();
    fetch_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      #2;
      n_checks++; if (issue_valid !== 1'b0) $display("FAIL stall_x5_%0d got %0b want 0", s, issue_valid); else n_pass++;
      tick();
    end
  endtask

  task automatic test_flush_wb();
    do_reset();
    stall_on_x5();
    flush = 1'b1; wb_valid = 1'b1; wb_waddr = 5'd5;
    #2;
    n_checks++; if (issue_valid !== 1'b0 || fetch_ready !== 1'b0) $display("FAIL flush_quiet got %0b%0b want 00", issue_valid, fetch_ready); else n_pass++;
    tick();
    flush = 1'b0; wb_valid = 1'b0;
    #2;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL flush_dropped got %0b want 0", issue_valid); else n_pass++;
    n_checks++; if (fetch_ready !== 1'b1) $display("FAIL flush_idle got %0b want 1", fetch_ready); else n_pass++;
    n_checks++; if (dut.busy !== 32'h0) $display("FAIL flush_busy got %h want 0", dut.busy); else n_pass++;
    n_checks++; if (stall_cnt !== 16'd2) $display("FAIL flush_stall got %0d want 2", stall_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    stall_on_x5();
    n_checks++; if (dut.busy[5] !== 1'b1) $display("FAIL mid_busy5 got %0b want 1", dut.busy[5]); else n_pass++;
    rst = 1'b1; issue_ready = 1'b1;
    #2;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL mid_rst_issue got %0b want 0", issue_valid); else n_pass++;
    tick();
    rst = 1'b0;
    #2;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL mid_issue got %0b want 0", issue_valid); else n_pass++;
    n_checks++; if (dut.busy !== 32'h0) $display("FAIL mid_busy got %h want 0", dut.busy); else n_pass++;
    n_checks++; if (stall_cnt !== 16'h0) $display("FAIL mid_stall got %0d want 0", stall_cnt); else n_pass++;
    n_checks++; if (fetch_ready !== 1'b1) $display("FAIL mid_ready got %0b want 1", fetch_ready); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] pc_ctr;
    int r;
    do_reset();
    pc_ctr = 64'h4000;
    for (int c = 0; c < 600; c++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0) fetch_instr = 32'h0;
      else if (r < 8) fetch_instr = addi($urandom_range(0, 7), $urandom_range(0, 7), r);
      else fetch_instr = add($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      fetch_pc    = pc_ctr;
      fetch_valid = ($urandom_range(0, 3) != 0);
      issue_ready = ($urandom_range(0, 3) != 0);
      wb_valid    = ($urandom_range(0, 2) == 0);
      wb_waddr    = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      #2;
      n_checks++; if (issue_valid !== exp_iv()) $display("FAIL rnd_issue_valid c%0d got %0b want %0b", c, issue_valid, exp_iv()); else n_pass++;
      n_checks++; if (fetch_ready !== exp_fr()) $display("FAIL rnd_fetch_ready c%0d got %0b want %0b", c, fetch_ready, exp_fr()); else n_pass++;
      n_checks++; if (trap !== m_trap) $display("FAIL rnd_trap c%0d got %0b want %0b", c, trap, m_trap); else n_pass++;
      n_checks++; if (trap_pc !== (m_trap ? m_pc : 64'h0)) $display("FAIL rnd_trap_pc c%0d got %h want %h", c, trap_pc, m_trap ? m_pc : 64'h0); else n_pass++;
      n_checks++; if (stall_cnt !== m_stall) $display("FAIL rnd_stall c%0d got %0d want %0d", c, stall_cnt, m_stall); else n_pass++;
      if (m_held) begin
        n_checks++; if (issue_pc !== m_pc || issue_instr !== m_instr) $display("FAIL rnd_held c%0d got %h/%h want %h/%h", c, issue_pc, issue_instr, m_pc, m_instr); else n_pass++;
        n_checks++; if (dec_instr !== m_instr) $display("FAIL rnd_dec_instr c%0d got %h want %h", c, dec_instr, m_instr); else n_pass++;
      end
      if (issue_valid && issue_ready) $display("issue pc=%h instr=%h", issue_pc, issue_instr);
      if (fetch_valid && fetch_ready) pc_ctr = pc_ctr + 64'd4;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_raw();
    test_x0();
    test_illegal();
    test_flush_wb();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
